// File: rtl/scv_pkg.sv
// Shared types and constants for the scv ROM-init loader: FSM states,
// address map of the boot bundle and cart, and the cart address-width helper.
package scv_pkg;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_DRAIN,
    LD_FINISH
  } loader_state_t;

  localparam logic [24:0] CHR_BASE       = 25'h0001000;
  localparam logic [24:0] CHR_END        = 25'h0001400;
  localparam logic [24:0] CART_MAX_BYTES = 25'h0020000;
  localparam int          CART_AW_MIN    = 12;
  localparam int          CART_AW_MAX    = 17;
  localparam logic [4:0]  CART_AW_RESET  = 5'd15;

  // One-hot target select, bit order {cart, chr, boot}.
  localparam logic [2:0] SEL_BOOT = 3'b001;
  localparam logic [2:0] SEL_CHR  = 3'b010;
  localparam logic [2:0] SEL_CART = 3'b100;

  // Bit-length of the highest cart byte offset, clamped to the supported widths.
  function automatic logic [4:0] cart_aw(input logic [16:0] max_addr);
    logic [4:0] len;
    len = 5'd0;
    for (int b = 0; b < 17; b++)
      if (max_addr[b]) len = 5'(b + 1);
    if (len < 5'(CART_AW_MIN)) len = 5'(CART_AW_MIN);
    else if (len > 5'(CART_AW_MAX)) len = 5'(CART_AW_MAX);
    return len;
  endfunction

endpackage

// File: rtl/rominit_pacer.sv
// One-entry write buffer with a minimum-gap counter between VALID pulses.
// The buffer contents drive the ROMINIT bus directly and hold between pulses.
module rominit_pacer #(
  parameter int VALID_GAP = 2
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        push,
  input  logic [2:0]  push_sel,
  input  logic [24:0] push_addr,
  input  logic [7:0]  push_data,
  output logic        full,
  output logic        accept,
  output logic        valid,
  output logic [2:0]  sel,
  output logic [24:0] addr,
  output logic [7:0]  data,
  output logic        overflow
);

  logic [3:0] gap_cnt;

  assign valid  = full && (gap_cnt == 4'd0);
  // A push in the draining cycle refills the slot instead of being dropped.
  assign accept = push && (!full || valid);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RES) begin
      // NOTE: the buffer payload is reset too, because it is the visible
      // ROMINIT bus and must read zero out of reset.
      full     <= 1'b0;
      sel      <= '0;
      addr     <= '0;
      data     <= '0;
      gap_cnt  <= 4'd0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        full <= 1'b1;
        sel  <= push_sel;
        addr <= push_addr;
        data <= push_data;
      end else if (valid) begin
        full <= 1'b0;
      end

      if (push && !accept) overflow <= 1'b1;

      if (valid) gap_cnt <= 4'(VALID_GAP - 1);
      else if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
    end
  end

endmodule

// File: rtl/rominit_loader.sv
// Turns the HPS ioctl download stream into ROMINIT writes for the scv core,
// tracks cart size for the ROM width config and holds the core while loading.
module rominit_loader
  import scv_pkg::*;
#(
  parameter int         VALID_GAP = 2,
  parameter logic [7:0] IDX_BOOT  = 8'd0,
  parameter logic [7:0] IDX_CART  = 8'd1
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        IOCTL_DOWNLOAD,
  input  logic [7:0]  IOCTL_INDEX,
  input  logic        IOCTL_WR,
  input  logic [24:0] IOCTL_ADDR,
  input  logic [7:0]  IOCTL_DATA,
  output logic        IOCTL_WAIT,
  output logic        ROMINIT_SEL_BOOT,
  output logic        ROMINIT_SEL_CHR,
  output logic        ROMINIT_SEL_CART,
  output logic [24:0] ROMINIT_ADDR,
  output logic [7:0]  ROMINIT_DATA,
  output logic        ROMINIT_VALID,
  output logic [4:0]  CART_ROM_AW,
  output logic        SYS_HOLD,
  output logic        OVERFLOW
);

  loader_state_t state, state_d;
  logic          dl_q;
  logic [7:0]    idx_q;
  logic [16:0]   cart_max;
  logic          push;
  logic [2:0]    push_sel;
  logic [24:0]   push_addr;
  logic          accept;
  logic          full;
  logic [2:0]    out_sel;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    push      = 1'b0;
    push_sel  = '0;
    push_addr = IOCTL_ADDR;

    unique case (state)
      LD_IDLE:   if (IOCTL_DOWNLOAD && !dl_q) state_d = LD_LOAD;
      LD_LOAD:   if (!IOCTL_DOWNLOAD) state_d = LD_DRAIN;
      LD_DRAIN:  if (!full) state_d = LD_FINISH;
      LD_FINISH: state_d = LD_IDLE;
      default:   state_d = LD_IDLE;
    endcase

    // A strobe in the cycle DOWNLOAD falls is still inside LOAD and is kept.
    if (state == LD_LOAD && IOCTL_WR) begin
      if (idx_q == IDX_BOOT) begin
        if (IOCTL_ADDR < CHR_BASE) begin
          push     = 1'b1;
          push_sel = SEL_BOOT;
        end else if (IOCTL_ADDR < CHR_END) begin
          push      = 1'b1;
          push_sel  = SEL_CHR;
          push_addr = IOCTL_ADDR - CHR_BASE;
        end
      end else if (idx_q == IDX_CART) begin
        if (IOCTL_ADDR < CART_MAX_BYTES) begin
          push     = 1'b1;
          push_sel = SEL_CART;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state       <= LD_IDLE;
      dl_q        <= 1'b0;
      idx_q       <= '0;
      cart_max    <= '0;
      CART_ROM_AW <= CART_AW_RESET;
      SYS_HOLD    <= 1'b1;
    end else begin
      state    <= state_d;
      dl_q     <= IOCTL_DOWNLOAD;
      SYS_HOLD <= (state_d != LD_IDLE);

      if (state == LD_IDLE && state_d == LD_LOAD) begin
        idx_q <= IOCTL_INDEX;
        if (IOCTL_INDEX == IDX_CART) cart_max <= '0;
      end else if (accept && push_sel == SEL_CART && IOCTL_ADDR[16:0] > cart_max) begin
        cart_max <= IOCTL_ADDR[16:0];
      end

      if (state == LD_FINISH && idx_q == IDX_CART) CART_ROM_AW <= cart_aw(cart_max);
    end
  end

  rominit_pacer #(
    .VALID_GAP (VALID_GAP)
  ) u_pacer (
    .CLK       (CLK),
    .RES       (RES),
    .push      (push),
    .push_sel  (push_sel),
    .push_addr (push_addr),
    .push_data (IOCTL_DATA),
    .full      (full),
    .accept    (accept),
    .valid     (ROMINIT_VALID),
    .sel       (out_sel),
    .addr      (ROMINIT_ADDR),
    .data      (ROMINIT_DATA),
    .overflow  (OVERFLOW)
  );

  assign IOCTL_WAIT       = full;
  assign ROMINIT_SEL_BOOT = out_sel[0];
  assign ROMINIT_SEL_CHR  = out_sel[1];
  assign ROMINIT_SEL_CART = out_sel[2];

endmodule

// File: tb/tb_rominit_loader.sv
// Bench for rominit_loader: instance 0 uses the default gap, instance 1 a gap
// of 4. A queue model of expected writes is checked on every VALID pulse.
module tb_rominit_loader;

  typedef struct packed {
    logic [2:0]  sel;
    logic [24:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        res [2];
  logic        dl  [2];
  logic        wr  [2];
  logic [7:0]  idx [2];
  logic [24:0] adr [2];
  logic [7:0]  dat [2];
  logic        wt  [2];
  logic        sb  [2];
  logic        sc  [2];
  logic        sk  [2];
  logic [24:0] ra  [2];
  logic [7:0]  rd  [2];
  logic        rv  [2];
  logic [4:0]  aw  [2];
  logic        hold[2];
  logic        ovf [2];

  int  n_total = 0;
  int  n_bad   = 0;
  int  cyc     = 0;
  int  vcnt[2];
  int  last_v[2];
  bit  chk_on  = 1'b0;
  wr_t exp_q0[$];
  wr_t exp_q1[$];
  int  vt_q1[$];
  logic [7:0]  cur_idx[2];
  logic [16:0] mmax[2];
  int          aw_exp[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rominit_loader u0 (
    .CLK(clk), .RES(res[0]), .IOCTL_DOWNLOAD(dl[0]), .IOCTL_INDEX(idx[0]),
    .IOCTL_WR(wr[0]), .IOCTL_ADDR(adr[0]), .IOCTL_DATA(dat[0]), .IOCTL_WAIT(wt[0]),
    .ROMINIT_SEL_BOOT(sb[0]), .ROMINIT_SEL_CHR(sc[0]), .ROMINIT_SEL_CART(sk[0]),
    .ROMINIT_ADDR(ra[0]), .ROMINIT_DATA(rd[0]), .ROMINIT_VALID(rv[0]),
    .CART_ROM_AW(aw[0]), .SYS_HOLD(hold[0]), .OVERFLOW(ovf[0])
  );

  rominit_loader #(.VALID_GAP(4)) u1 (
    .CLK(clk), .RES(res[1]), .IOCTL_DOWNLOAD(dl[1]), .IOCTL_INDEX(idx[1]),
    .IOCTL_WR(wr[1]), .IOCTL_ADDR(adr[1]), .IOCTL_DATA(dat[1]), .IOCTL_WAIT(wt[1]),
    .ROMINIT_SEL_BOOT(sb[1]), .ROMINIT_SEL_CHR(sc[1]), .ROMINIT_SEL_CART(sk[1]),
    .ROMINIT_ADDR(ra[1]), .ROMINIT_DATA(rd[1]), .ROMINIT_VALID(rv[1]),
    .CART_ROM_AW(aw[1]), .SYS_HOLD(hold[1]), .OVERFLOW(ovf[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Spec-level decode: which target a byte lands on and where, or dropped.
  function automatic bit model_decode(input logic [7:0] ix, input logic [24:0] a, output wr_t e);
    e.addr = a;
    e.sel  = 3'b000;
    e.data = 8'h00;
    if (ix == 8'd0) begin
      if (a < 25'h1000) begin e.sel = 3'b001; return 1'b1; end
      if (a < 25'h1400) begin e.sel = 3'b010; e.addr = a - 25'h1000; return 1'b1; end
      return 1'b0;
    end
    if (ix == 8'd1 && a < 25'h20000) begin e.sel = 3'b100; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic int model_aw(input int m);
    int w = 0;
    while ((1 << w) <= m) w++;
    if (w < 12) w = 12;
    if (w > 17) w = 17;
    return w;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  always @(negedge clk) begin : compare
    wr_t e;
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        if (rv[k] === 1'b1) begin
          vcnt[k]++;
          if (qsize(k) == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL spurious_valid u%0d: got VALID, want none (t=%0t)", k, $time);
          end else begin
            if (k == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            check("valid_sel",  32'({sk[k], sc[k], sb[k]}), 32'(e.sel));
            check("valid_addr", 32'(ra[k]), 32'(e.addr));
            check("valid_data", 32'(rd[k]), 32'(e.data));
          end
          if (last_v[k] >= 0)
            check("valid_gap_min", 32'((cyc - last_v[k]) >= ((k == 0) ? 2 : 4)), 32'd1);
          last_v[k] = cyc;
          if (k == 1) vt_q1.push_back(cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_dl(input int k, input logic [7:0] ix);
    dl[k]      = 1'b1;
    idx[k]     = ix;
    cur_idx[k] = ix;
    if (ix == 8'd1) mmax[k] = '0;
    step();
  endtask

  task automatic send(input int k, input logic [24:0] a, input logic [7:0] d,
                      input bit honor, input bit dropped);
    wr_t e;
    bit  ok;
    int  n = 0;
    if (honor) begin
      while (wt[k] !== 1'b0 && n < 200) begin step(); n++; end
      if (n >= 200) timeout_fail("wait_release");
    end
    wr[k]  = 1'b1;
    adr[k] = a;
    dat[k] = d;
    ok     = model_decode(cur_idx[k], a, e);
    e.data = d;
    if (ok && !dropped) begin
      if (k == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
      if (cur_idx[k] == 8'd1 && a[16:0] > mmax[k]) mmax[k] = a[16:0];
    end
    step();
    wr[k] = 1'b0;
  endtask

  task automatic end_dl(input int k);
    int n = 0;
    dl[k] = 1'b0;
    while (hold[k] !== 1'b0 && n < 400) begin step(); n++; end
    if (n >= 400) timeout_fail("hold_release");
    if (cur_idx[k] == 8'd1) aw_exp[k] = model_aw(int'(mmax[k]));
    check("cart_rom_aw", 32'(aw[k]), 32'(aw_exp[k]));
    check("queue_drained", 32'(qsize(k)), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int v0;
    for (int k = 0; k < 2; k++) begin
      res[k] = 1'b1; dl[k] = 1'b0; wr[k] = 1'b0; idx[k] = '0; adr[k] = '0; dat[k] = '0;
      vcnt[k] = 0; last_v[k] = -1; cur_idx[k] = '0; mmax[k] = '0; aw_exp[k] = 15;
    end
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < 2; k++) begin
      check("rst_wait",  32'(wt[k]), 32'd0);
      check("rst_valid", 32'(rv[k]), 32'd0);
      check("rst_sel",   32'({sk[k], sc[k], sb[k]}), 32'd0);
      check("rst_addr",  32'(ra[k]), 32'd0);
      check("rst_data",  32'(rd[k]), 32'd0);
      check("rst_aw",    32'(aw[k]), 32'd15);
      check("rst_hold",  32'(hold[k]), 32'd1);
      check("rst_ovf",   32'(ovf[k]), 32'd0);
    end
    res[0] = 1'b0;
    res[1] = 1'b0;
    chk_on = 1'b1;
    step();
    check("hold_after_rst_u0", 32'(hold[0]), 32'd0);
    check("hold_after_rst_u1", 32'(hold[1]), 32'd0);

    // Boot bundle on the default-gap instance.
    begin_dl(0, 8'd0);
    send(0, 25'h0FFF, 8'hA5, 1'b1, 1'b0);
    @(negedge clk);
    check("boot_fff_addr", 32'(ra[0]), 32'h0FFF);
    check("boot_fff_sel",  32'({sk[0], sc[0], sb[0]}), 32'b001);
    step();
    send(0, 25'h1000, 8'h5A, 1'b1, 1'b0);
    @(negedge clk);
    check("chr_1000_addr", 32'(ra[0]), 32'h0000);
    check("chr_1000_sel",  32'({sk[0], sc[0], sb[0]}), 32'b010);
    step();
    send(0, 25'h13FF, 8'h3C, 1'b1, 1'b0);
    step();
    send(0, 25'h1400, 8'hC3, 1'b1, 1'b0);
    @(negedge clk);
    check("boot_1400_novalid", 32'(rv[0]), 32'd0);
    check("boot_1400_addr_held", 32'(ra[0]), 32'h03FF);
    step();
    end_dl(0);
    check("boot_valid_count", 32'(vcnt[0]), 32'd3);

    // 32 KiB cart; SYS_HOLD drops after one DRAIN and one FINISH cycle.
    v0 = vcnt[0];
    begin_dl(0, 8'd1);
    for (int a = 0; a < 32768; a++)
      send(0, 25'(a), 8'(a) ^ 8'(a >> 8), 1'b1, 1'b0);
    dl[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("cart_hold_tail", 32'(hold[0]), (i < 3) ? 32'd1 : 32'd0);
    end
    step();
    end_dl(0);
    check("cart32k_valids", 32'(vcnt[0] - v0), 32'd32768);
    check("cart32k_aw", 32'(aw[0]), 32'd15);

    // Gap of 4 with a well-behaved sender: pulses exactly 4 apart.
    begin_dl(1, 8'd1);
    vt_q1.delete();
    for (int i = 0; i < 6; i++) send(1, 25'(i), 8'(8'h40 + i), 1'b1, 1'b0);
    end_dl(1);
    check("burst_pulses", 32'(vt_q1.size()), 32'd6);
    for (int i = 1; i < vt_q1.size(); i++)
      check("burst_spacing", 32'(vt_q1[i] - vt_q1[i-1]), 32'd4);
    check("burst_ovf", 32'(ovf[1]), 32'd0);

    // Sender ignoring WAIT: the byte arriving while the slot is busy is lost.
    repeat (6) step();
    begin_dl(1, 8'd1);
    send(1, 25'h10, 8'h11, 1'b0, 1'b0);
    send(1, 25'h11, 8'h22, 1'b0, 1'b0);
    send(1, 25'h12, 8'h33, 1'b0, 1'b1);
    end_dl(1);
    check("ignore_wait_ovf", 32'(ovf[1]), 32'd1);

    // 100-byte cart narrows the ROM width to the minimum.
    begin_dl(1, 8'd1);
    for (int a = 0; a < 100; a++) send(1, 25'(a), 8'(a * 3), 1'b1, 1'b0);
    end_dl(1);
    check("cart100_aw", 32'(aw[1]), 32'd12);

    // Unknown index: nothing written, width kept.
    v0 = vcnt[1];
    begin_dl(1, 8'd5);
    for (int a = 0; a < 4; a++) send(1, 25'(a), 8'hEE, 1'b1, 1'b0);
    end_dl(1);
    check("idx5_no_valid", 32'(vcnt[1] - v0), 32'd0);
    check("idx5_aw_kept", 32'(aw[1]), 32'd12);
    check("ovf_sticky", 32'(ovf[1]), 32'd1);

    // Reset in the middle of a cart load with a byte still buffered.
    begin_dl(1, 8'd1);
    send(1, 25'h20, 8'h77, 1'b1, 1'b0);
    send(1, 25'h21, 8'h88, 1'b1, 1'b0);
    check("pending_wait", 32'(wt[1]), 32'd1);
    res[1] = 1'b1;
    dl[1]  = 1'b0;
    exp_q1.delete();
    aw_exp[1] = 15;
    step();
    res[1] = 1'b0;
    check("midrst_valid", 32'(rv[1]), 32'd0);
    check("midrst_wait",  32'(wt[1]), 32'd0);
    check("midrst_aw",    32'(aw[1]), 32'd15);
    check("midrst_hold",  32'(hold[1]), 32'd1);
    check("midrst_ovf",   32'(ovf[1]), 32'd0);
    step();
    check("midrst_idle_hold", 32'(hold[1]), 32'd0);
    repeat (6) step();
    check("midrst_no_late_valid", 32'(qsize(1)), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
